// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the exception/interrupt sequencer: exception codes,
// FSM state encodings, counter width and the taken-event kind.
package exc_ctrl_pkg;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_PIL = 6'h01;
    localparam logic [5:0] ECODE_PIS = 6'h02;
    localparam logic [5:0] ECODE_PIF = 6'h03;
    localparam logic [5:0] ECODE_PME = 6'h04;
    localparam logic [5:0] ECODE_PPI = 6'h07;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;
    localparam logic [5:0] ECODE_SYS = 6'h0B;
    localparam logic [5:0] ECODE_BRK = 6'h0C;
    localparam logic [5:0] ECODE_INE = 6'h0D;
    localparam logic [5:0] ECODE_IPE = 6'h0E;
    localparam logic [5:0] ECODE_TLBR = 6'h3F;

    localparam logic [8:0] ESUBCODE_ADEF = 9'h000;
    localparam logic [8:0] ESUBCODE_ADEM = 9'h001;

    localparam logic [1:0] EXC_ST_IDLE     = 2'd0;
    localparam logic [1:0] EXC_ST_COMMIT   = 2'd1;
    localparam logic [1:0] EXC_ST_REDIRECT = 2'd2;
    localparam logic [1:0] EXC_ST_DRAIN    = 2'd3;

    localparam int EXC_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        KIND_NONE = 2'd0,
        KIND_INT  = 2'd1,
        KIND_EXC  = 2'd2,
        KIND_ERTN = 2'd3
    } exc_kind_t;

endpackage

// File: rtl/exc_ctrl_prio_sel.sv
// Combinational priority select (interrupt > exception > ertn) producing the
// taken event kind and the payload that will be latched for the CSR block.
module exc_prio_sel
    import exc_ctrl_pkg::*;
(
    input  logic        wb_valid,
    input  logic        int_req,
    input  logic        wb_ex_in,
    input  logic        wb_ertn_in,
    input  logic [5:0]  wb_ecode_in,
    input  logic [8:0]  wb_esubcode_in,
    input  logic [31:0] wb_pc_in,
    input  logic [31:0] wb_vaddr_in,
    output logic        take,
    output exc_kind_t   kind,
    output logic [5:0]  ecode,
    output logic [8:0]  esubcode,
    output logic [31:0] pc,
    output logic [31:0] vaddr
);

    always_comb begin
        kind     = KIND_NONE;
        ecode    = 6'h00;
        esubcode = 9'h000;
        pc       = wb_pc_in;
        vaddr    = 32'h0;
        if (wb_valid && int_req) begin
            kind  = KIND_INT;
            ecode = ECODE_INT;
        end else if (wb_valid && wb_ex_in) begin
            kind     = KIND_EXC;
            ecode    = wb_ecode_in;
            esubcode = wb_esubcode_in;
            vaddr    = wb_vaddr_in;
        end else if (wb_valid && wb_ertn_in) begin
            kind = KIND_ERTN;
        end
    end

    assign take = (kind != KIND_NONE);

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer between WB and the CSR block: pulses the CSR,
// redirects fetch, drains. Interrupt detection is enabled by EXC_CTRL_INT_EN.
module exc_ctrl
    import exc_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        wb_valid,
    input  logic        wb_ex_in,
    input  logic [5:0]  wb_ecode_in,
    input  logic [8:0]  wb_esubcode_in,
    input  logic        wb_ertn_in,
    input  logic [31:0] wb_pc_in,
    input  logic [31:0] wb_vaddr_in,
    input  logic [12:0] int_is,
    input  logic [12:0] int_lie,
    input  logic        crmd_ie,
    input  logic [31:0] ex_entry,
    output logic        csr_wb_ex,
    output logic        csr_ertn_flush,
    output logic [5:0]  csr_ecode,
    output logic [8:0]  csr_esubcode,
    output logic [31:0] csr_pc,
    output logic [31:0] csr_vaddr,
    output logic        commit_block,
    output logic        pipe_flush,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ready,
    output logic        busy
);

    localparam logic [EXC_CNT_WIDTH-1:0] DRAIN_LOAD = EXC_CNT_WIDTH'(FLUSH_CYCLES - 1);

    logic [1:0]               state;
    logic [EXC_CNT_WIDTH-1:0] cnt;
    exc_kind_t                kind_q;
    logic                     int_req;
    logic                     sel_take;
    exc_kind_t                sel_kind;
    logic [5:0]               sel_ecode;
    logic [8:0]               sel_esubcode;
    logic [31:0]              sel_pc;
    logic [31:0]              sel_vaddr;

`ifdef EXC_CTRL_INT_EN
    assign int_req = crmd_ie & (|(int_is & int_lie));
`else
    logic unused_int;
    assign unused_int = crmd_ie ^ (^int_is) ^ (^int_lie);
    assign int_req    = 1'b0;
`endif

    exc_prio_sel u_prio_sel (
        .wb_valid       (wb_valid),
        .int_req        (int_req),
        .wb_ex_in       (wb_ex_in),
        .wb_ertn_in     (wb_ertn_in),
        .wb_ecode_in    (wb_ecode_in),
        .wb_esubcode_in (wb_esubcode_in),
        .wb_pc_in       (wb_pc_in),
        .wb_vaddr_in    (wb_vaddr_in),
        .take           (sel_take),
        .kind           (sel_kind),
        .ecode          (sel_ecode),
        .esubcode       (sel_esubcode),
        .pc             (sel_pc),
        .vaddr          (sel_vaddr)
    );

    // DRAIN leaves on the edge where the count reaches zero, so the next
    // accept lands FLUSH_CYCLES cycles after the redirect handshake.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= EXC_ST_IDLE;
            cnt          <= '0;
            kind_q       <= KIND_NONE;
            csr_ecode    <= 6'h00;
            csr_esubcode <= 9'h000;
            csr_pc       <= 32'h0;
            csr_vaddr    <= 32'h0;
            redirect_pc  <= 32'h0;
        end else begin
            case (state)
                EXC_ST_IDLE: begin
                    if (sel_take) begin
                        state        <= EXC_ST_COMMIT;
                        kind_q       <= sel_kind;
                        csr_ecode    <= sel_ecode;
                        csr_esubcode <= sel_esubcode;
                        csr_pc       <= sel_pc;
                        csr_vaddr    <= sel_vaddr;
                    end
                end
                EXC_ST_COMMIT: begin
                    redirect_pc <= ex_entry;
                    state       <= EXC_ST_REDIRECT;
                end
                EXC_ST_REDIRECT: begin
                    if (redirect_ready) begin
                        if (DRAIN_LOAD == '0) begin
                            state <= EXC_ST_IDLE;
                        end else begin
                            state <= EXC_ST_DRAIN;
                            cnt   <= DRAIN_LOAD;
                        end
                    end
                end
                EXC_ST_DRAIN: begin
                    cnt <= cnt - 1'b1;
                    if (cnt <= 1) begin
                        state <= EXC_ST_IDLE;
                    end
                end
                default: begin
                    state <= EXC_ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign busy           = (state != EXC_ST_IDLE);
    assign pipe_flush     = busy;
    assign redirect_valid = (state == EXC_ST_REDIRECT);
    assign csr_wb_ex      = (state == EXC_ST_COMMIT) && (kind_q != KIND_ERTN);
    assign csr_ertn_flush = (state == EXC_ST_COMMIT) && (kind_q == KIND_ERTN);
    assign commit_block   = busy | sel_take;

endmodule

// File: tb/tb_exc_ctrl.sv
// Randomized self-checking bench for exc_ctrl; the event model follows the
// take/priority rules directly and tracks EXC_CTRL_INT_EN like the design.
module tb_exc_ctrl;

    localparam int FLUSH = 2;

    logic        clk = 1'b0;
    logic        resetn;
    logic        wb_valid;
    logic        wb_ex_in;
    logic [5:0]  wb_ecode_in;
    logic [8:0]  wb_esubcode_in;
    logic        wb_ertn_in;
    logic [31:0] wb_pc_in;
    logic [31:0] wb_vaddr_in;
    logic [12:0] int_is;
    logic [12:0] int_lie;
    logic        crmd_ie;
    logic [31:0] ex_entry;
    logic        csr_wb_ex;
    logic        csr_ertn_flush;
    logic [5:0]  csr_ecode;
    logic [8:0]  csr_esubcode;
    logic [31:0] csr_pc;
    logic [31:0] csr_vaddr;
    logic        commit_block;
    logic        pipe_flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exc_ctrl #(.FLUSH_CYCLES(FLUSH)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .wb_valid       (wb_valid),
        .wb_ex_in       (wb_ex_in),
        .wb_ecode_in    (wb_ecode_in),
        .wb_esubcode_in (wb_esubcode_in),
        .wb_ertn_in     (wb_ertn_in),
        .wb_pc_in       (wb_pc_in),
        .wb_vaddr_in    (wb_vaddr_in),
        .int_is         (int_is),
        .int_lie        (int_lie),
        .crmd_ie        (crmd_ie),
        .ex_entry       (ex_entry),
        .csr_wb_ex      (csr_wb_ex),
        .csr_ertn_flush (csr_ertn_flush),
        .csr_ecode      (csr_ecode),
        .csr_esubcode   (csr_esubcode),
        .csr_pc         (csr_pc),
        .csr_vaddr      (csr_vaddr),
        .commit_block   (commit_block),
        .pipe_flush     (pipe_flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready),
        .busy           (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit intPending(input logic [12:0] is, input logic [12:0] lie, input bit ie);
`ifdef EXC_CTRL_INT_EN
        return ie && ((is & lie) != 13'h0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic clearInputs();
        wb_valid       = 1'b0;
        wb_ex_in       = 1'b0;
        wb_ertn_in     = 1'b0;
        wb_ecode_in    = 6'h0;
        wb_esubcode_in = 9'h0;
        wb_pc_in       = 32'h0;
        wb_vaddr_in    = 32'h0;
        int_is         = 13'h0;
        int_lie        = 13'h0;
        crmd_ie        = 1'b0;
    endtask

    // One event from IDLE through COMMIT, REDIRECT (stalled for 'stall'
    // cycles while noise is applied on WB/ex_entry) and DRAIN back to IDLE.
    task automatic applyStimulus(input bit v, input bit ex, input bit er,
                                 input logic [5:0] ec, input logic [8:0] es,
                                 input logic [31:0] pc, input logic [31:0] va,
                                 input logic [12:0] is, input logic [12:0] lie, input bit ie,
                                 input logic [31:0] entry, input int stall);
        bit ireq, take, is_int, is_exc;
        int drain;
        @(negedge clk);
        wb_valid = v; wb_ex_in = ex; wb_ertn_in = er;
        wb_ecode_in = ec; wb_esubcode_in = es; wb_pc_in = pc; wb_vaddr_in = va;
        int_is = is; int_lie = lie; crmd_ie = ie;
        ex_entry = entry; redirect_ready = 1'b0;
        ireq   = intPending(is, lie, ie);
        take   = v && (ireq || ex || er);
        is_int = v && ireq;
        is_exc = v && !ireq && ex;
        #1;
        checkOutput("idle_commit_block", commit_block, take);
        checkOutput("idle_busy", busy, 0);
        if (!take) begin
            @(negedge clk);
            checkOutput("noevt_busy", busy, 0);
            checkOutput("noevt_wb_ex", csr_wb_ex, 0);
            checkOutput("noevt_ertn", csr_ertn_flush, 0);
            clearInputs();
            return;
        end
        @(negedge clk);
        checkOutput("commit_wb_ex", csr_wb_ex, is_int || is_exc);
        checkOutput("commit_ertn", csr_ertn_flush, !(is_int || is_exc));
        checkOutput("commit_flush", pipe_flush, 1);
        checkOutput("commit_block", commit_block, 1);
        if (is_int || is_exc) begin
            checkOutput("commit_ecode", csr_ecode, is_int ? 6'h00 : ec);
            checkOutput("commit_esub", csr_esubcode, is_int ? 9'h0 : es);
            checkOutput("commit_pc", csr_pc, pc);
            checkOutput("commit_vaddr", csr_vaddr, is_int ? 32'h0 : va);
        end
        wb_valid = 1'b1; wb_ex_in = 1'b1; wb_ecode_in = ~ec;
        @(negedge clk);
        checkOutput("redir_valid", redirect_valid, 1);
        checkOutput("redir_pc", redirect_pc, entry);
        checkOutput("redir_wb_ex", csr_wb_ex, 0);
        checkOutput("redir_ertn", csr_ertn_flush, 0);
        ex_entry = ~entry;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checkOutput("stall_valid", redirect_valid, 1);
            checkOutput("stall_pc", redirect_pc, entry);
            checkOutput("stall_flush", pipe_flush, 1);
            checkOutput("stall_wb_ex", csr_wb_ex, 0);
        end
        redirect_ready = 1'b1;
        clearInputs();
        @(negedge clk);
        redirect_ready = 1'b0;
        checkOutput("drain_redir_valid", redirect_valid, 0);
        drain = 0;
        while (busy && drain < 40) begin
            checkOutput("drain_flush", pipe_flush, 1);
            drain++;
            @(negedge clk);
        end
        checkOutput("drain_len", drain, FLUSH - 1);
    endtask

    initial begin
        resetn = 1'b0;
        clearInputs();
        ex_entry = 32'h0;
        redirect_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_redir_pc", redirect_pc, 0);
        checkOutput("rst_csr_pc", csr_pc, 0);
        resetn = 1'b1;

        applyStimulus(1, 1, 0, 6'h0B, 9'h0, 32'h1C000100, 32'h0, 13'h0, 13'h0, 0, 32'h1C008000, 0);
        applyStimulus(1, 0, 1, 6'h00, 9'h0, 32'h1C000200, 32'h0, 13'h0, 13'h0, 0, 32'h1C000104, 0);
        applyStimulus(1, 1, 1, 6'h0B, 9'h3, 32'h1C000300, 32'hDEADBEEF, 13'h800, 13'h800, 1, 32'h1C008000, 0);
        applyStimulus(1, 0, 0, 6'h00, 9'h0, 32'h1C000400, 32'h0, 13'h800, 13'h800, 0, 32'h1C008000, 0);
        applyStimulus(1, 0, 0, 6'h00, 9'h0, 32'h1C000400, 32'h0, 13'h800, 13'h000, 1, 32'h1C008000, 0);
        applyStimulus(1, 1, 0, 6'h08, 9'h1, 32'h1C000500, 32'h00001234, 13'h0, 13'h0, 0, 32'h1C008000, 5);

        for (int n = 0; n < 40; n++) begin
            applyStimulus($urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          6'($urandom), 9'($urandom), $urandom, $urandom,
                          ($urandom_range(0, 1) != 0) ? 13'($urandom) : 13'h0, 13'($urandom),
                          1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 5));
        end

        // Reset asserted while holding a redirect
        @(negedge clk);
        wb_valid = 1'b1; wb_ex_in = 1'b1; wb_ecode_in = 6'h0C; wb_pc_in = 32'h1C000600;
        ex_entry = 32'h1C008000; redirect_ready = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("pre_rst_redir", redirect_valid, 1);
        resetn = 1'b0;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_flush", pipe_flush, 0);
        checkOutput("midrst_redir_valid", redirect_valid, 0);
        checkOutput("midrst_redir_pc", redirect_pc, 0);
        checkOutput("midrst_ecode", csr_ecode, 0);
        checkOutput("midrst_pc", csr_pc, 0);
        checkOutput("midrst_wb_ex", csr_wb_ex, 0);
        checkOutput("midrst_block_take", commit_block, 1);
        clearInputs();
        #1;
        checkOutput("midrst_block_idle", commit_block, 0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("postrst_busy", busy, 0);
        applyStimulus(1, 1, 0, 6'h0D, 9'h0, 32'h1C000700, 32'h0, 13'h0, 13'h0, 0, 32'h1C008800, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
